// File: rtl/onehot_pulse_decoder_if.sv
// ---------------------------------------------------------------------------
// onehot_pulse_decoder_if
// Input handshake between an index producer and onehot_pulse_decoder.
//   in_valid : producer has an index this cycle
//   in_idx   : binary index to decode (IN_W bits)
//   in_ready : decoder can take it; a transfer happens on in_valid && in_ready
// master = producer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface onehot_pulse_decoder_if #(
  parameter int IN_W = 2
);
  logic            in_valid;
  logic [IN_W-1:0] in_idx;
  logic            in_ready;

  modport master (output in_valid, output in_idx, input in_ready);
  modport slave  (input in_valid, input in_idx, output in_ready);
endinterface

// File: rtl/onehot_pulse_decoder.sv
// ---------------------------------------------------------------------------
// onehot_pulse_decoder
// Turns a stream of binary indices into timed one-hot pulses. Each index
// taken from a small input FIFO drives line 1<<idx high for HOLD cycles,
// followed by GAP all-zero cycles.
// Ports:
//   clk        : clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   en         : gates FIFO acceptance and the start of new pulses
//   in_if      : slave side of the index handshake (valid/idx/ready)
//   out        : registered one-hot pulse output (2**IN_W bits)
//   out_active : registered, high exactly when out != 0
//   busy       : pulse/gap in progress or entries still queued
// ---------------------------------------------------------------------------
module onehot_pulse_decoder #(
  parameter int IN_W  = 2,
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  onehot_pulse_decoder_if.slave  in_if,
  output logic [(2**IN_W)-1:0]   out,
  output logic                   out_active,
  output logic                   busy
);

  localparam int OUT_W   = 2**IN_W;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W  = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(HOLD - 1);
  // Only used when GAP > 0; the guard keeps the value sane for GAP == 0.
  localparam logic [CNT_W-1:0]  GAP_INIT  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  // FIFO storage and pointers
  logic [IN_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;

  // Pulse FSM
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_active_q, out_active_d;

  logic empty, full, push, pop, load, load_ok;
  logic [IN_W-1:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign head    = mem_q[rd_ptr_q];
  assign load_ok = en && !empty;

  // Ready ignores a same-cycle pop so it never depends on FSM decisions.
  assign in_if.in_ready = rst_n && en && !full;
  assign push           = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.in_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_ok) begin
          load = 1'b1;
        end else begin
          out_d = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          out_d   = '0;
          cnt_d   = GAP_INIT;
        end else if (load_ok) begin
          // Back-to-back pulse: the next line rises with no zero cycle.
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
          out_d   = '0;
        end
      end
      S_GAP: begin
        out_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (load_ok) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      state_d = S_HOLD;
      out_d   = OUT_W'(1) << head;
      cnt_d   = HOLD_INIT;
    end

    // A pop only ever happens on a load, and load implies non-empty.
    pop          = load;
    out_active_d = |out_d;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      out_q        <= '0;
      out_active_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_active_q <= out_active_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign out        = out_q;
  assign out_active = out_active_q;
  assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: doc/onehot_pulse_decoder.md
Name: onehot_pulse_decoder

Overview:
- Sequential counterpart of the priority encoder: turns a stream of binary indices back into timed one-hot output pulses.
- Each accepted index drives line `1<<idx` high for HOLD cycles, then the output is all-zero for GAP cycles.
- A small input FIFO decouples the producer.
- Sits downstream of an encoder/arbiter and drives per-channel strobes (LED/actuator/select lines).

Parameters:
- IN_W, 2, index width; output width is 2**IN_W.
- HOLD, 4, cycles each one-hot pulse is held high (>=1).
- GAP, 1, all-zero cycles after each pulse (>=0).
- DEPTH, 2, input FIFO depth (power of 2, >=2).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  decode enable; gates acceptance and the start of new pulses.
- in_valid  input  1  in_idx is valid this cycle.
- in_idx  input  IN_W  binary index to decode.
- in_ready  output  1  FIFO can accept; transfer occurs when in_valid && in_ready.
- out  output  2**IN_W  one-hot pulse output, registered.
- out_active  output  1  high exactly when out != 0, registered.
- busy  output  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (rst_n low at a rising edge):
  - out=0, out_active=0, FSM=IDLE, FIFO empty, counter=0.
  - in_ready=0 while rst_n is low.
  - Reset mid-pulse aborts the pulse: out=0 on the next cycle and queued entries are discarded.
- in_ready = rst_n && en && !full. Combinational, not dependent on a same-cycle pop; no push when full.
- FIFO:
  - Circular buffer, wrapping read/write pointers, occupancy count 0..DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop occurs only on an FSM load; there is never a pop while empty.
- Load condition: en && !empty, evaluated when the FSM can start a pulse. A load:
  - pops the FIFO head;
  - sets out = 1<<head;
  - sets counter = HOLD-1;
  - enters HOLD.
- FSM states:
  - IDLE:
    - Load condition true -> load.
    - Otherwise stay, out=0.
  - HOLD:
    - out held; counter decrements each cycle.
    - At counter==0:
      - GAP>0 -> enter GAP, out=0, counter=GAP-1.
      - GAP==0 and load condition -> load next entry (back-to-back pulses, no zero cycle).
      - Otherwise -> IDLE, out=0.
  - GAP:
    - out=0; counter decrements.
    - At counter==0: load condition -> load directly; otherwise -> IDLE.
- Latency:
  - Index accepted in cycle k into an empty FIFO with FSM IDLE -> out asserted in cycles k+2 .. k+1+HOLD.
  - Pulse length is exactly HOLD cycles; gap is exactly GAP cycles.
- en low:
  - No new accepts and no new loads.
  - A pulse or gap in progress completes normally.
  - Queued entries wait until en returns high.
- out is always zero or exactly one-hot. out_active == |out.
- busy deasserts the first cycle the FSM is IDLE with the FIFO empty.

Test Plan (IN_W=2, HOLD=4, GAP=1, DEPTH=2 unless noted):
1. Single index: idx=2, in_valid=1 in cycle 0 only.
   - out=4'b0100 in cycles 2-5.
   - out=0 in cycle 6.
   - busy=0 from cycle 7.
2. Burst: idx=0,1,3 in cycles 0,1,2 (all accepted).
   - out=0001 in cycles 2-5, 0 in cycle 6.
   - out=0010 in cycles 7-10, 0 in cycle 11.
   - out=1000 in cycles 12-15.
   - in_ready=0 in cycles 3-6, 1 again in cycle 7.
3. Enable gating:
   - en dropped in cycle 3 of pulse 0001 with idx=1 queued.
   - Pulse still ends after cycle 5.
   - out stays 0 and in_ready=0 while en is low.
   - en raised in cycle 10 -> out=0010 from cycle 11.
4. Reset mid-pulse:
   - rst_n=0 in cycle 3 of a pulse with 1 entry queued.
   - out=0, out_active=0, busy=0 in cycle 4.
   - After release the queued entry is never emitted.
5. GAP=0 back-to-back: idx=3 then idx=0.
   - out=1000 in cycles 2-5.
   - out=0001 in cycles 6-9.
   - No zero cycle between the two pulses.
6. Full/wrap: push 6 indices 0,1,2,3,0,1 under backpressure.
   - All six appear in order, each as a one-hot pulse.
   - Every pulse is exactly 4 cycles, with exactly 1 zero cycle between pulses.
   - No entry is lost or duplicated across pointer wrap.
